// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// uart_tx_frame
//   Parametrised UART transmitter: state machine, bit timer, bit counter and
//   shift register in one block. A frame is a start bit, WORD_LENGTH data bits
//   (LSB first), an optional parity bit and STOP_BITS stop bits.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit follows the data bits (even, or odd when
//                  PARITY_ODD=1), computed from data_in at the accept edge
//     undefined -> no parity state or logic; PARITY_ODD is ignored
//
//   state  | meaning
//   -------+-----------------------------------------------------
//   IDLE   | line high, ready=1, waiting for transmit
//   START  | start bit (low) for one bit period
//   DATA   | WORD_LENGTH data bits, LSB first
//   PARITY | parity bit for one bit period (UART_TX_PARITY_EN only)
//   STOP   | STOP_BITS stop bits (high)
//   DONE   | single cycle, TX_flag=1, then back to IDLE
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   data_in    in   word to send, latched on the accept edge
//   transmit   in   send request, accepted only while ready=1
//   ready      out  high only in IDLE
//   busy       out  ~ready
//   serial_out out  registered serial line, idles high
//   TX_flag    out  one-cycle pulse after the last stop bit
module uart_tx_frame #(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 208,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   transmit,
  output logic                   ready,
  output logic                   busy,
  output logic                   serial_out,
  output logic                   TX_flag
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_LENGTH + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(WORD_LENGTH - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd5
`endif
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [TW-1:0]          timer_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [WORD_LENGTH-1:0] shift_q;
  logic                   serial_d;
  logic                   bit_end;
  logic                   accept;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign bit_end = (timer_q == TIMER_LAST);
  assign busy    = ~ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // serial_d is the value the line should carry for the current state; it is
  // registered into serial_out, which gives the one-cycle launch latency.
  always_comb begin
    state_d  = state_q;
    serial_d = 1'b1;
    ready    = 1'b0;
    TX_flag  = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (transmit) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        serial_d = shift_q[0];
        if (bit_end && (bit_cnt_q == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = parity_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end && (bit_cnt_q == STOP_LAST)) state_d = DONE;
      end
      DONE: begin
        TX_flag = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serial_out <= 1'b1;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      serial_out <= serial_d;

      if ((state_q == IDLE) || (state_q == DONE) || bit_end) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      // The same counter tracks data bits and then stop bits; it clears
      // whenever the state it was counting for is left.
      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
      end else if (((state_q == DATA) || (state_q == STOP)) && bit_end) begin
        if (state_d != state_q) bit_cnt_q <= '0;
        else                    bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (accept) begin
        shift_q <= data_in;
      end else if ((state_q == DATA) && bit_end) begin
        shift_q <= shift_q >> 1;
      end

`ifdef UART_TX_PARITY_EN
      if (accept) parity_q <= (^data_in) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int W = 8;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data1, data2;
  logic       tx1, tx2;
  logic       ready1, busy1, so1, flag1;
  logic       ready2, busy2, so2, flag2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // instance 1: one stop bit, even parity; instance 2: two stop bits, odd parity
  uart_tx_frame #(.WORD_LENGTH(W), .CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .data_in(data1), .transmit(tx1),
    .ready(ready1), .busy(busy1), .serial_out(so1), .TX_flag(flag1));

  uart_tx_frame #(.WORD_LENGTH(W), .CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .data_in(data2), .transmit(tx2),
    .ready(ready2), .busy(busy2), .serial_out(so2), .TX_flag(flag2));

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         exp_busy;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  function automatic int stop_of(input int sel);
    return (sel == 1) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int sel);
    return (1 + W + P + stop_of(sel)) * C;
  endfunction

  // Reference line value in cycle k after the accept edge (k=1 is the cycle
  // right after the edge): frame bits are laid out as start, data LSB first,
  // optional parity, stop bits, each C cycles long, starting in cycle 2.
  function automatic logic exp_line(input int sel, input logic [7:0] d, input int k);
    int   b;
    logic pb;
    if (k < 2 || k > frame_len(sel) + 1) return 1'b1;
    b = (k - 2) / C;
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (P == 1 && b == W + 1) begin
      pb = ^d;
      if (sel == 2) pb = ~pb;
      return pb;
    end
    return 1'b1;
  endfunction

  function automatic logic get_so(input int sel);
    return (sel == 1) ? so1 : so2;
  endfunction
  function automatic logic get_ready(input int sel);
    return (sel == 1) ? ready1 : ready2;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction
  function automatic logic get_flag(input int sel);
    return (sel == 1) ? flag1 : flag2;
  endfunction

  task automatic drive(input int sel, input logic t, input logic [7:0] d);
    if (sel == 1) begin tx1 = t; data1 = d; end
    else          begin tx2 = t; data2 = d; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic report(input string name, input int nerr, input int k, input logic a, input logic e);
    checks++;
    if (nerr != 0) begin
      failures++;
      $display("FAIL %s: %0d cycle(s) differ, first at cycle %0d actual=%b required=%b",
               name, nerr, k, a, e);
    end
  endtask

  // Waits (bounded) for ready, then presents one word; returns in cycle 1.
  task automatic start(input int sel, input logic [7:0] d, input logic hold);
    int n = 0;
    while (get_ready(sel) !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL start_timeout ready stayed low for %0d cycles", n);
    end
    drive(sel, 1'b1, d);
    @(posedge clk); #1;
    if (!hold) drive(sel, 1'b0, ~d);
  endtask

  task automatic check_frame(input int sel, input logic [7:0] d, input string name,
                             input int inject, input logic hold,
                             output logic par_seen, output int busy_len);
    int   f = frame_len(sel);
    int   e_so = 0, e_fl = 0, e_rd = 0;
    int   k_so = 0, k_fl = 0, k_rd = 0;
    logic a_so = 0, x_so = 0, a_fl = 0, x_fl = 0, a_rd = 0, x_rd = 0;
    logic exp_fl, exp_rd;
    par_seen = 1'b0;
    busy_len = 0;
    for (int k = 1; k <= f + 2; k++) begin
      if (!hold && k == inject)     drive(sel, 1'b1, 8'hFF);
      if (!hold && k == inject + 1) drive(sel, 1'b0, 8'hFF);
      exp_fl = (k == f + 1);
      exp_rd = (k == f + 2);
      if (get_so(sel) !== exp_line(sel, d, k)) begin
        if (e_so == 0) begin k_so = k; a_so = get_so(sel); x_so = exp_line(sel, d, k); end
        e_so++;
      end
      if (get_flag(sel) !== exp_fl) begin
        if (e_fl == 0) begin k_fl = k; a_fl = get_flag(sel); x_fl = exp_fl; end
        e_fl++;
      end
      if (get_ready(sel) !== exp_rd || get_busy(sel) !== ~exp_rd) begin
        if (e_rd == 0) begin k_rd = k; a_rd = get_ready(sel); x_rd = exp_rd; end
        e_rd++;
      end
      if (k == 2 + (W + 1) * C) par_seen = get_so(sel);
      if (get_ready(sel) === 1'b0) busy_len++;
      if (k < f + 2) begin
        @(posedge clk); #1;
      end
    end
    report({name, "_serial"}, e_so, k_so, a_so, x_so);
    report({name, "_txflag"}, e_fl, k_fl, a_fl, x_fl);
    report({name, "_ready"},  e_rd, k_rd, a_rd, x_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       par;
    int         blen;
    int         sel;
    int         bad;

    vecs[0] = '{1, 8'hA5, (10 + P) * C + 1, 1'b0};
    vecs[1] = '{2, 8'hA5, (11 + P) * C + 1, 1'b1};
    vecs[2] = '{1, 8'h01, (10 + P) * C + 1, 1'b1};
    vecs[3] = '{2, 8'h3C, (11 + P) * C + 1, 1'b1};
    vecs[4] = '{1, 8'hFF, (10 + P) * C + 1, 1'b0};
    vecs[5] = '{2, 8'h80, (11 + P) * C + 1, 1'b0};

    reset = 1'b0;
    tx1 = 1'b0; tx2 = 1'b0; data1 = 8'h00; data2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_serial", so1, 1);
    check("reset_ready",  ready1, 1);
    check("reset_busy",   busy1, 0);
    check("reset_txflag", flag1, 0);
    reset = 1'b1;

    // idle after release
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (so1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0 || flag1 !== 1'b0 ||
          so2 !== 1'b1 || ready2 !== 1'b1 || busy2 !== 1'b0 || flag2 !== 1'b0) bad++;
    end
    check("idle_after_reset_bad_cycles", bad, 0);

    // directed table
    foreach (vecs[i]) begin
      start(vecs[i].sel, vecs[i].data, 1'b0);
      check_frame(vecs[i].sel, vecs[i].data, $sformatf("vec%0d", i), 0, 1'b0, par, blen);
      check($sformatf("vec%0d_busy_cycles", i), blen, vecs[i].exp_busy);
`ifdef UART_TX_PARITY_EN
      check($sformatf("vec%0d_parity", i), int'(par), int'(vecs[i].exp_par));
`endif
    end

    // two stop bits, transmit pulse mid-frame must be ignored
    start(2, 8'h00, 1'b0);
    check_frame(2, 8'h00, "stop2_ignore", 10, 1'b0, par, blen);
    check("stop2_ignore_busy_cycles", blen, frame_len(2) + 1);

    // reset in the middle of a frame
    start(1, 8'hA5, 1'b0);
    repeat (14) begin @(posedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    check("abort_serial", so1, 1);
    check("abort_ready",  ready1, 1);
    check("abort_busy",   busy1, 0);
    check("abort_txflag", flag1, 0);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (flag1 !== 1'b0 || so1 !== 1'b1) bad++;
    end
    reset = 1'b1;
    repeat (frame_len(1) + 4) begin
      @(posedge clk); #1;
      if (flag1 !== 1'b0 || so1 !== 1'b1 || ready1 !== 1'b1) bad++;
    end
    check("abort_quiet_bad_cycles", bad, 0);
    start(1, 8'h3C, 1'b0);
    check_frame(1, 8'h3C, "after_abort", 0, 1'b0, par, blen);

    // transmit held high: frames back to back, F+2 apart
    start(1, 8'h55, 1'b1);
    check_frame(1, 8'h55, "b2b0", 0, 1'b1, par, blen);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      check_frame(1, 8'h55, $sformatf("b2b%0d", i), 0, 1'b1, par, blen);
    end
    drive(1, 1'b0, 8'h00);
    repeat (frame_len(1) + 3) begin @(posedge clk); #1; end

    // randomized frames against the reference layout
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(1, 2));
      d   = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      start(sel, d, 1'b0);
      check_frame(sel, d, $sformatf("rand%0d", i), int'($urandom_range(3, 30)), 1'b0, par, blen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter: FSM, bit timer, bit counter and shift register in one block.
Generalises the fixed 8-bit TX FSM with configurable word length, baud divisor and stop-bit count, plus a ready/transmit handshake.
Sits between the MIPS memory-mapped UART register and the serial pin.
Replaces the separate TX FSM + shift-register pair.

Parameters:
WORD_LENGTH, 8, data bits per frame; legal 5..16.
CLKS_PER_BIT, 208, clk cycles per serial bit; legal >= 2.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WORD_LENGTH  word to send; sampled only on the accept edge
transmit  input  1  send request; accepted when ready=1
ready  output  1  high only in IDLE; block can accept a word
busy  output  1  high from accept until DONE completes; equals ~ready
serial_out  output  1  serial line; idles high; registered output
TX_flag  output  1  one-cycle pulse when the last stop bit has finished

Behaviour:
- Reset (async, reset=0), all outputs immediately:
  - State=IDLE, serial_out=1, ready=1, busy=0, TX_flag=0.
  - Shift register, bit timer and bit counter cleared.
- Reset mid-frame aborts the frame; the line returns high without completing it.
- Accept: rising edge with transmit=1 and ready=1.
  - data_in is latched into the shift register on that edge; state goes to START.
  - transmit is ignored while ready=0; no queueing.
- States and transitions:
  - IDLE -> START on accept.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: WORD_LENGTH bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary. After the last bit: PARITY if compiled in, else STOP.
  - PARITY: one bit period, then STOP.
  - STOP: serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then DONE.
  - DONE: exactly one cycle with TX_flag=1 and serial_out=1, then IDLE.
  - Illegal state encodings go to IDLE.
- Timing:
  - serial_out first goes low on the clock edge after the accept edge (1-cycle latency).
  - Frame length F = (1 + WORD_LENGTH + P + STOP_BITS) * CLKS_PER_BIT cycles; P = 1 with parity, 0 without.
  - TX_flag is high in cycle F+1 after the accept edge.
  - ready returns high in cycle F+2.
  - Back-to-back frames: the minimum accept-to-accept distance is F+2 cycles.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width $clog2(CLKS_PER_BIT).
  - Held at 0 in IDLE and DONE.
- Bit counter:
  - Counts data bits 0..WORD_LENGTH-1; width $clog2(WORD_LENGTH+1).
  - The stop-bit count reuses the bit counter.
- serial_out is driven from a register; it is never combinationally derived from state.
- Changes on data_in after the accept edge do not affect the frame in flight.

Optional Feature:
Macro: UART_TX_PARITY_EN
- Defined:
  - The PARITY state is present.
  - Parity bit = XOR of the latched word when PARITY_ODD=0; inverted XOR when PARITY_ODD=1.
  - Parity is computed at the accept edge from data_in.
  - P = 1 in the frame length.
- Undefined:
  - No PARITY state, no parity logic; PARITY_ODD is ignored.
  - P = 0.

Test Plan:
1. Reset hold, then release with transmit=0 for 20 cycles -> serial_out=1, ready=1, busy=0, TX_flag=0 throughout.
2. WORD_LENGTH=8, CLKS_PER_BIT=4, STOP_BITS=1, no parity; send 0xA5 -> serial_out shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). TX_flag pulses in cycle 41; ready=1 in cycle 42.
3. Same configuration with UART_TX_PARITY_EN:
   - 0xA5, PARITY_ODD=0 -> parity bit 0.
   - 0xA5, PARITY_ODD=1 -> parity bit 1.
   - 0x01, PARITY_ODD=0 -> parity bit 1.
   - Frame is 44 cycles in each case.
4. STOP_BITS=2, send 0x00 -> serial_out low for 36 cycles, then high for 8 cycles, then TX_flag pulse. A transmit pulse mid-frame with data 0xFF is ignored and the frame is unchanged.
5. Assert reset=0 at cycle 15 of a 0xA5 frame -> serial_out=1 and ready=1 with no clock edge; TX_flag never pulses; a new 0x3C frame after release is correct.
6. Hold transmit=1 continuously with data_in=0x55 -> consecutive frames start exactly F+2 cycles apart, each bit-exact.
